systolic_feed_ctrl: RTL and testbench
=====================================

SYSTOLIC_FEED_CTRL -- requirements
Module: systolic_feed_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 8: number of transpose FIFO lanes and matrix rows.
REQ-002 SHALL have parameter BITS, default 8: element width.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1: request to load and feed one matrix.
REQ-006 SHALL have port abort, input, 1: synchronous cancel of the current operation.
REQ-007 SHALL have port mem_rd, output, 1: row read request to memory.
REQ-008 SHALL have port mem_addr, output, $clog2(DEPTH): row address.
REQ-009 SHALL have port mem_rdata, input, DEPTH x BITS unpacked array: row data, valid exactly 1 cycle after mem_rd.
REQ-010 SHALL have port fifo_ain, output, DEPTH x BITS unpacked array: row data broadcast to all FIFO lanes.
REQ-011 SHALL have port fifo_wren, output, DEPTH: per-lane parallel-load enable, at most one bit set.
REQ-012 SHALL have port fifo_en, output, DEPTH: per-lane shift enable.
REQ-013 SHALL have port busy, output, 1: high from the first LOAD cycle through the DONE cycle.
REQ-014 SHALL have port done, output, 1: one-cycle completion pulse.

Function
REQ-015 SHALL implement an FSM with states IDLE, LOAD, DRAIN, FEED, DONE.
REQ-016 IDLE -> LOAD SHALL occur when start=1 and abort=0; start SHALL be ignored in every other state.
REQ-017 LOAD SHALL last DEPTH cycles; in LOAD cycle r, mem_rd=1 and mem_addr=r, for r=0..DEPTH-1.
REQ-018 fifo_wren[r] SHALL be 1 exactly in the cycle after row r is requested; fifo_ain SHALL equal mem_rdata combinationally in that cycle.
REQ-019 DRAIN SHALL be one cycle, writing row DEPTH-1; LOAD -> DRAIN -> FEED unconditionally absent abort.
REQ-020 FEED SHALL use a cycle counter k from 0 to 2*DEPTH-2; fifo_en[i]=1 iff i <= k <= i+DEPTH-1.
REQ-021 After k=2*DEPTH-2, the FSM SHALL enter DONE for one cycle with done=1, then return to IDLE.
REQ-022 All outputs except fifo_ain SHALL be registered; fifo_wren and fifo_en SHALL never be 1 in the same cycle.
REQ-023 abort=1 in any non-IDLE state SHALL force IDLE on the next edge with done never asserted; all enables SHALL be 0 from that edge on.
REQ-024 abort and start both 1 in IDLE: abort SHALL win and the FSM SHALL stay in IDLE.
REQ-025 Counter widths SHALL hold 2*DEPTH-1 without wrap; mem_addr SHALL never exceed DEPTH-1.

Reset
REQ-026 rst_n=0 SHALL force IDLE and clear the counters immediately, regardless of clock.
REQ-027 During reset, mem_rd, mem_addr, fifo_wren, fifo_en, busy and done SHALL be 0.
REQ-028 Reset deasserted mid-operation SHALL resume in IDLE with no done pulse; a new start SHALL then be accepted normally.

Configuration
REQ-029 Macro FEED_SKEW_EN defined: FEED SHALL behave per REQ-020 (diagonal skew, 2*DEPTH-1 cycles).
REQ-030 FEED_SKEW_EN undefined: FEED SHALL last DEPTH cycles with all fifo_en bits 1 together; all other behaviour SHALL be unchanged.

Verification (DEPTH=8, BITS=8, start pulsed in cycle C0)
REQ-031 Nominal load: mem_rdata row r = {8{r+1}} -> mem_rd=1, addr 0..7 in C1..C8; fifo_wren one-hot bit r in C(r+2), fifo_ain = row r.
REQ-032 Skewed feed (FEED_SKEW_EN): fifo_en[0]=1 in C10..C17, fifo_en[7]=1 in C17..C24; done=1 in C25 only; busy=1 in C1..C25.
REQ-033 Unskewed feed (no macro): fifo_en=8'hFF in C10..C17; done in C18; busy low from C19.
REQ-034 Abort in C12: all enables 0 from C13, busy=0 in C13, no done pulse; start in C14 restarts with addr 0 in C15.
REQ-035 start held high through an operation and start+abort together in IDLE -> no second operation begins before done, and abort suppresses the start.
REQ-036 rst_n low asynchronously at mid-cycle during C5 -> all outputs 0 immediately; after release, FSM is in IDLE and no done pulse occurs.

Source files
------------

// File: rtl/systolic_feed_ctrl_if.sv
// Bus bundle for systolic_feed_ctrl: control handshake, row memory read port, transpose-FIFO lane controls.
// master = controller side, slave = environment (memory, FIFO array, sequencer).
interface systolic_feed_ctrl_if #(
  parameter int DEPTH = 8,
  parameter int BITS  = 8
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic             start;
  logic             abort;
  logic             mem_rd;
  logic [AW-1:0]    mem_addr;
  logic [BITS-1:0]  mem_rdata [DEPTH];
  logic [BITS-1:0]  fifo_ain  [DEPTH];
  logic [DEPTH-1:0] fifo_wren;
  logic [DEPTH-1:0] fifo_en;
  logic             busy;
  logic             done;

  modport master (
    input  start, abort, mem_rdata,
    output mem_rd, mem_addr, fifo_ain, fifo_wren, fifo_en, busy, done
  );

  modport slave (
    output start, abort, mem_rdata,
    input  mem_rd, mem_addr, fifo_ain, fifo_wren, fifo_en, busy, done
  );
endinterface

// File: rtl/systolic_feed_ctrl.sv
// Loads a DEPTH x DEPTH matrix row by row into transpose FIFO lanes, then feeds it out.
// Define FEED_SKEW_EN for the diagonal-skew feed; otherwise all lanes shift together for DEPTH cycles.
module systolic_feed_ctrl #(
  parameter int DEPTH = 8,
  parameter int BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  systolic_feed_ctrl_if.master bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(2 * DEPTH);
`ifdef FEED_SKEW_EN
  localparam int FEED_LAST = 2 * DEPTH - 2;
`else
  localparam int FEED_LAST = DEPTH - 1;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN,
    S_FEED,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             mem_rd_q, mem_rd_d;
  logic [AW-1:0]    mem_addr_q, mem_addr_d;
  logic [DEPTH-1:0] wren_q, wren_d;
  logic [DEPTH-1:0] en_q, en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= '0;
      wren_q     <= '0;
      en_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mem_rd_q   <= mem_rd_d;
      mem_addr_q <= mem_addr_d;
      wren_q     <= wren_d;
      en_q       <= en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Outputs are decoded from the next state/count so every output is a flop.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wren_d     = '0;
    en_d       = '0;
    mem_rd_d   = 1'b0;
    mem_addr_d = '0;
    busy_d     = 1'b0;
    done_d     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (bus.start && !bus.abort) begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        // Row cnt_q is requested this cycle; its data lands next cycle.
        wren_d[cnt_q[AW-1:0]] = 1'b1;
        if (cnt_q == CW'(DEPTH - 1)) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DRAIN: begin
        state_d = S_FEED;
        cnt_d   = '0;
      end
      S_FEED: begin
        if (cnt_q == CW'(FEED_LAST)) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    if (state_q != S_IDLE && bus.abort) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      wren_d  = '0;
    end

    mem_rd_d = (state_d == S_LOAD);
    if (state_d == S_LOAD) begin
      mem_addr_d = cnt_d[AW-1:0];
    end

    if (state_d == S_FEED) begin
`ifdef FEED_SKEW_EN
      for (int unsigned i = 0; i < DEPTH; i++) begin
        en_d[i] = (cnt_d >= CW'(i)) && (cnt_d <= CW'(i + DEPTH - 1));
      end
`else
      en_d = '1;
`endif
    end

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  assign bus.mem_rd    = mem_rd_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.fifo_wren = wren_q;
  assign bus.fifo_en   = en_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.fifo_ain  = bus.mem_rdata;

endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// Scoreboard bench for systolic_feed_ctrl: a timeline model (offset since start) predicts every cycle's outputs.
// Honours FEED_SKEW_EN the same way as the design.
module tb_systolic_feed_ctrl;
  localparam int D  = 8;
  localparam int B  = 8;
  localparam int AW = $clog2(D);
`ifdef FEED_SKEW_EN
  localparam int FL = 2 * D - 2;
`else
  localparam int FL = D - 1;
`endif
  localparam int DONE_OFF = D + 3 + FL;

  typedef struct {
    logic          mem_rd;
    logic [AW-1:0] addr;
    logic [D-1:0]  wren;
    logic [D-1:0]  en;
    logic          busy;
    logic          done;
    logic [D*B-1:0] ain;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  systolic_feed_ctrl_if #(.DEPTH(D), .BITS(B)) bus ();
  systolic_feed_ctrl #(.DEPTH(D), .BITS(B)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [B-1:0] rows [D][D];
  exp_t sbq[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   cur    = 0;
  logic mon_en = 1'b0;

  function automatic exp_t model(input int o);
    exp_t e;
    int   k;
    e.mem_rd = 1'b0; e.addr = '0; e.wren = '0; e.en = '0;
    e.busy = 1'b0; e.done = 1'b0; e.ain = '0;
    if (o >= 1 && o <= D) begin
      e.mem_rd = 1'b1;
      e.addr   = AW'(o - 1);
    end
    if (o >= 2 && o <= D + 1) begin
      e.wren = D'(1) << (o - 2);
      for (int j = 0; j < D; j++) e.ain[j*B +: B] = rows[o-2][j];
    end
    k = o - (D + 2);
    if (k >= 0 && k <= FL) begin
      for (int i = 0; i < D; i++) begin
`ifdef FEED_SKEW_EN
        e.en[i] = (k >= i) && (k <= i + D - 1);
`else
        e.en[i] = 1'b1;
`endif
      end
    end
    e.busy = (o >= 1);
    e.done = (o == DONE_OFF);
    return e;
  endfunction

  task automatic step(input logic st, input logic ab);
    int nxt;
    @(negedge clk);
    bus.start = st;
    bus.abort = ab;
    if (cur == 0)             nxt = (st && !ab) ? 1 : 0;
    else if (ab)              nxt = 0;
    else if (cur == DONE_OFF) nxt = 0;
    else                      nxt = cur + 1;
    sbq.push_back(model(nxt));
    cur = nxt;
  endtask

  task automatic idle_steps(input int n);
    repeat (n) step(1'b0, 1'b0);
  endtask

  task automatic check_zero(input string name, input logic [31:0] act);
    n_chk++;
    if (act == 0) n_pass++;
    else $display("FAIL %s: got %h, expected 0", name, act);
  endtask

  task automatic check_reset_outputs();
    check_zero("rst_mem_rd", 32'(bus.mem_rd));
    check_zero("rst_mem_addr", 32'(bus.mem_addr));
    check_zero("rst_fifo_wren", 32'(bus.fifo_wren));
    check_zero("rst_fifo_en", 32'(bus.fifo_en));
    check_zero("rst_busy", 32'(bus.busy));
    check_zero("rst_done", 32'(bus.done));
  endtask

  task automatic set_rows(input bit nominal);
    for (int r = 0; r < D; r++)
      for (int j = 0; j < D; j++)
        rows[r][j] = nominal ? B'(r + 1) : B'($urandom);
  endtask

  // Memory responder: data for the address requested in one cycle appears in the next.
  initial begin
    logic          pend;
    logic [AW-1:0] paddr;
    for (int j = 0; j < D; j++) bus.mem_rdata[j] = '0;
    forever begin
      @(negedge clk);
      pend  = bus.mem_rd;
      paddr = bus.mem_addr;
      @(posedge clk);
      #1;
      for (int j = 0; j < D; j++) bus.mem_rdata[j] = pend ? rows[paddr][j] : B'($urandom);
    end
  end

  // Monitor: one scoreboard entry per cycle, sampled 2 time units after the edge.
  initial begin
    exp_t e;
    logic [D*B-1:0] ain;
    int cyc = 0;
    forever begin
      @(posedge clk);
      #2;
      cyc++;
      if (mon_en) begin
        if (sbq.size() == 0) begin
          n_chk++;
          $display("FAIL scoreboard_underflow at cycle %0d: got empty queue, expected an entry", cyc);
        end else begin
          e = sbq.pop_front();
          n_chk++;
          if (bus.mem_rd === e.mem_rd && bus.mem_addr === e.addr && bus.fifo_wren === e.wren &&
              bus.fifo_en === e.en && bus.busy === e.busy && bus.done === e.done)
            n_pass++;
          else
            $display("FAIL ctrl cycle %0d: got rd=%b addr=%0d wren=%h en=%h busy=%b done=%b, expected rd=%b addr=%0d wren=%h en=%h busy=%b done=%b",
                     cyc, bus.mem_rd, bus.mem_addr, bus.fifo_wren, bus.fifo_en, bus.busy, bus.done,
                     e.mem_rd, e.addr, e.wren, e.en, e.busy, e.done);
          if (e.wren != '0) begin
            for (int j = 0; j < D; j++) ain[j*B +: B] = bus.fifo_ain[j];
            n_chk++;
            if (ain === e.ain) n_pass++;
            else $display("FAIL fifo_ain cycle %0d: got %h, expected %h", cyc, ain, e.ain);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    set_rows(1'b1);
    #1;
    check_reset_outputs();
    repeat (2) @(posedge clk);
    #3;
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Nominal load and feed.
    step(1'b1, 1'b0);
    idle_steps(DONE_OFF + 2);

    // Abort in C12, restart in C14.
    set_rows(1'b0);
    step(1'b1, 1'b0);
    idle_steps(11);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    idle_steps(DONE_OFF + 2);

    // start held high across operations, then start+abort together in IDLE.
    repeat (2 * DONE_OFF + 4) step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    repeat (4) step(1'b1, 1'b1);
    idle_steps(2);

    // Asynchronous reset mid-cycle during C5, then a fresh operation.
    set_rows(1'b0);
    step(1'b1, 1'b0);
    idle_steps(5);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    mon_en = 1'b0;
    cur    = 0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst_n  = 1'b1;
    mon_en = 1'b1;
    idle_steps(3);
    step(1'b1, 1'b0);
    idle_steps(DONE_OFF + 2);

    // Random traffic.
    repeat (600) begin
      if (cur == 0 && $urandom_range(0, 3) == 0) set_rows(1'b0);
      step($urandom_range(0, 3) == 0, $urandom_range(0, 29) == 0);
    end
    idle_steps(DONE_OFF + 2);

    @(posedge clk);
    #3;
    mon_en = 1'b0;
    n_chk++;
    if (sbq.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sbq.size());

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
